width_conv_arbiter: RTL and testbench

WIDTH_CONV_ARBITER -- requirements
Module: width_conv_arbiter

---
 rtl/width_conv_arbiter.sv | 133 +++++++++++++
 tb/tb_width_conv_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/width_conv_arbiter.sv
// width_conv_arbiter
//   Two-requester round-robin arbiter that feeds 24-bit beats into a 24-to-128
//   width converter. A grant is held for whole 16-beat groups (up to
//   GROUPS_PER_GRANT groups). Every grant is followed by at least one IDLE
//   cycle.
//
//   Optional feature (macro WCA_STALL_PAD_EN): if the granted requester stalls
//   for 64 consecutive cycles mid-group, the rest of the group is filled with
//   zero pad beats and the grant ends.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req{0,1}_valid/_data    requester beat and 24-bit payload
//   req{0,1}_ready          combinational accept (only in own grant, not padding)
//   conv_valid/_data        registered beat to converter (latency 1)
//   conv_owner              0 = req0, 1 = req1
//   conv_pad                beat is a pad beat (0 when feature compiled out)
//   grp_done                pulse with the 16th beat of a group
module width_conv_arbiter #(
  parameter int GROUPS_PER_GRANT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [23:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_data,
  output logic        req1_ready,
  output logic        conv_valid,
  output logic [23:0] conv_data,
  output logic        conv_owner,
  output logic        conv_pad,
  output logic        grp_done
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [2:0] LAST_GRP = 3'(GROUPS_PER_GRANT - 1);

  state_t      state, state_nx;
  logic [3:0]  beat_cnt;
  logic [2:0]  grp_cnt;
  logic        rr_ptr;      // requester that wins the next tie
  logic        granted, own, vld_own, padding;
  logic [23:0] data_own;
  logic        acc, beat, wrap, stall, grant_end;

  assign granted  = (state != IDLE);
  assign own      = (state == GRANT1);
  assign vld_own  = own ? req1_valid : req0_valid;
  assign data_own = own ? req1_data  : req0_data;

`ifdef WCA_STALL_PAD_EN
  logic [7:0] stall_cnt;
  logic       pad_q;
  assign padding = pad_q;
`else
  assign padding = 1'b0;
`endif

  assign req0_ready = (state == GRANT0) && !padding;
  assign req1_ready = (state == GRANT1) && !padding;

  assign acc   = granted && vld_own && !padding;
  assign beat  = acc || (granted && padding);
  assign wrap  = beat && (beat_cnt == 4'hF);
  assign stall = granted && (beat_cnt != 4'h0) && !vld_own && !padding;

  // A padded group always ends the grant; otherwise end on the last group's
  // wrap or when the owner has nothing to send at a group boundary.
  assign grant_end = granted &&
                     ((wrap && (padding || grp_cnt == LAST_GRP)) ||
                      (beat_cnt == 4'h0 && !vld_own && !padding));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_nx = rr_ptr ? GRANT1 : GRANT0;
        else if (req0_valid)          state_nx = GRANT0;
        else if (req1_valid)          state_nx = GRANT1;
      end
      default: if (grant_end) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= 4'h0;
      grp_cnt    <= 3'h0;
      rr_ptr     <= 1'b0;
      conv_valid <= 1'b0;
      conv_data  <= 24'h0;
      conv_owner <= 1'b0;
      grp_done   <= 1'b0;
    end else begin
      state <= state_nx;
      if (beat) beat_cnt <= beat_cnt + 4'h1;
      if (grant_end)  grp_cnt <= 3'h0;
      else if (wrap)  grp_cnt <= grp_cnt + 3'h1;
      if (grant_end) rr_ptr <= ~own;
      conv_valid <= beat;
      conv_data  <= acc ? data_own : 24'h0;
      conv_owner <= beat ? own : 1'b0;
      grp_done   <= wrap;
    end
  end

`ifdef WCA_STALL_PAD_EN
  logic conv_pad_q;
  assign conv_pad = conv_pad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= 8'h0;
      pad_q      <= 1'b0;
      conv_pad_q <= 1'b0;
    end else begin
      if (!granted || acc || grant_end) stall_cnt <= 8'h0;
      else if (stall)                   stall_cnt <= stall_cnt + 8'h1;
      // 64th consecutive stall cycle switches to padding from the next cycle
      if (grant_end)                            pad_q <= 1'b0;
      else if (stall && stall_cnt == 8'd63)     pad_q <= 1'b1;
      conv_pad_q <= granted && padding;
    end
  end
`else
  assign conv_pad = 1'b0;
`endif

endmodule

// File: tb/tb_width_conv_arbiter.sv
// Testbench for width_conv_arbiter: randomized and directed stimulus, a
// behavioural transaction model producing expected ready and converter beats,
// and a monitor that pops the expected beats as the DUT emits them.
module tb_width_conv_arbiter;
  localparam int G = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        conv_valid, conv_owner, conv_pad, grp_done;
  logic [23:0] conv_data;

  width_conv_arbiter #(.GROUPS_PER_GRANT(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_owner(conv_owner),
    .conv_pad(conv_pad), .grp_done(grp_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        own;
    logic        pad;
    logic        done;
  } beat_t;

  beat_t q[$];
  int checks = 0, errors = 0;

  // model state: grant held, owner, tie winner, padding, position in grant
  bit m_grant = 0, m_own = 0, m_ptr = 0, m_pad = 0;
  int m_beats = 0, m_groups = 0, m_stall = 0;
  beat_t mb, cb;
  logic [1:0] mv, mer;

  // Model: at each falling edge, the inputs seen are those the DUT samples on
  // the next rising edge. Predict ready, predict what gets emitted.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_grant = 0; m_ptr = 0; m_pad = 0; m_beats = 0; m_groups = 0; m_stall = 0;
      q.delete();
    end else begin
      mv  = {req1_valid, req0_valid};
      mer = 2'b00;
      if (m_grant) mer[m_own] = !m_pad;
      checks++;
      if ({req1_ready, req0_ready} !== mer) begin
        errors++;
        $display("FAIL ready t=%0t got %b want %b", $time, {req1_ready, req0_ready}, mer);
      end
      if (!m_grant) begin
        if (mv != 2'b00) begin
          m_own = (mv == 2'b11) ? m_ptr : mv[1];
          m_grant = 1; m_beats = 0; m_groups = 0; m_stall = 0; m_pad = 0;
        end
      end else if (m_pad || mv[m_own]) begin
        mb.data = m_pad ? 24'h0 : (m_own ? req1_data : req0_data);
        mb.own  = m_own;
        mb.pad  = m_pad;
        mb.done = (m_beats == 15);
        q.push_back(mb);
        m_stall = 0;
        if (m_beats == 15) begin
          m_beats = 0;
          m_groups++;
          if (m_pad || m_groups == G) begin
            m_grant = 0; m_ptr = !m_own; m_pad = 0;
          end
        end else m_beats++;
      end else if (m_beats == 0) begin
        m_grant = 0; m_ptr = !m_own;
      end else begin
`ifdef WCA_STALL_PAD_EN
        m_stall++;
        if (m_stall == 64) m_pad = 1;
`endif
      end
    end
  end

  // Monitor: anything emitted must match the head of the queue, exactly one
  // cycle after it was predicted.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      checks++;
      if (conv_valid) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat t=%0t data %h owner %b pad %b", $time, conv_data, conv_owner, conv_pad);
        end else begin
          cb = q.pop_front();
          if (conv_data !== cb.data || conv_owner !== cb.own || conv_pad !== cb.pad || grp_done !== cb.done) begin
            errors++;
            $display("FAIL beat t=%0t got d=%h o=%b p=%b g=%b want d=%h o=%b p=%b g=%b", $time,
                     conv_data, conv_owner, conv_pad, grp_done, cb.data, cb.own, cb.pad, cb.done);
          end
        end
      end else if (q.size() != 0 || conv_pad !== 1'b0 || grp_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_out t=%0t pending %0d pad %b grp_done %b want 0 0 0", $time, q.size(), conv_pad, grp_done);
        if (q.size() != 0) cb = q.pop_front();
      end
    end
  end

  task automatic drv(input bit a, input bit b, input int n);
    repeat (n) begin
      @(posedge clk); #3;
      req0_valid = a; req1_valid = b;
      req0_data = 24'($urandom); req1_data = 24'($urandom);
    end
  endtask

  task automatic chk_zero(input string tag);
    logic [31:0] outs;
    outs = {conv_valid, conv_owner, conv_pad, grp_done, req0_ready, req1_ready, 2'b00, conv_data};
    checks++;
    if (outs !== 32'h0) begin
      errors++;
      $display("FAIL %s outputs %h want 0", tag, outs);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_state");
    #2 rst_n = 1'b1;

    // boundary release: req0 one group then drops while req1 waits
    drv(1, 1, 17);
    drv(0, 1, 40);
    // contention
    drv(1, 1, 90);
    // idle out, then mid-group stall of req1 while req0 waits
    drv(0, 0, 3);
    drv(0, 1, 6);
    drv(1, 0, 10);
    drv(1, 1, 30);
    // random traffic
    for (int i = 0; i < 1500; i++)
      drv($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70, 1);
    // reset mid-group
    drv(0, 0, 3);
    drv(1, 0, 8);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    drv(1, 1, 2);
    @(posedge clk); #3 rst_n = 1'b1;
    drv(1, 1, 20);
    // long stall: pads when feature is compiled in, endless wait otherwise
    drv(0, 0, 3);
    drv(1, 0, 4);
    drv(0, 0, 75);
    drv(0, 1, 40);
    drv(0, 0, 3);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
